// File: rtl/ripplecarry4_deskew.sv
// rtl/ripplecarry4_deskew.sv - realigns bit-skewed adder output into a 2-entry result FIFO
module ripplecarry4_deskew (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sum,
  input  logic       cout,
  input  logic       in_valid,
  output logic [4:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  output logic [7:0] count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} fifo_state_t;

  fifo_state_t state, state_nxt;

  logic [2:0] s0_d;
  logic [1:0] s1_d;
  logic       s2_d;
  logic [2:0] v_d;
  logic [4:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;

  logic [4:0] aligned;
  logic       v3;
  logic       pop;
  logic       push;
  logic       drop;

  // Lower bits arrive earlier, so each gets one stage less than the bit below it.
  assign aligned = {cout, sum[3], s2_d, s1_d[1], s0_d[2]};
  assign v3      = v_d[2];

  assign out_valid = (state != EMPTY);
  assign out_data  = out_valid ? mem[rd_ptr] : 5'b0;

  assign pop  = out_valid & out_ready;
  assign push = v3 & ((state != FULL) | pop);
  assign drop = v3 & (state == FULL) & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_d <= 3'b0;
      s1_d <= 2'b0;
      s2_d <= 1'b0;
      v_d  <= 3'b0;
    end else begin
      s0_d <= {s0_d[1:0], sum[0]};
      s1_d <= {s1_d[0], sum[1]};
      s2_d <= sum[2];
      v_d  <= {v_d[1:0], in_valid};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      mem[0]   <= 5'b0;
      mem[1]   <= 5'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      overflow <= 1'b0;
      count    <= 8'h00;
    end else begin
      state <= state_nxt;
      if (push) begin
        mem[wr_ptr] <= aligned;
        wr_ptr      <= ~wr_ptr;
        count       <= count + 8'd1;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:    if (pop && !push) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

endmodule

// File: doc/ripplecarry4_deskew.md
RIPPLECARRY4_DESKEW -- requirements
Module: ripplecarry4_deskew

Interface
REQ-001 The block SHALL have the port `clk`, an input of width 1: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst`, an input of width 1: reset, asynchronous and active-low.
REQ-003 The block SHALL have the port `sum`, an input of width 4: bit-skewed sum from the upstream registered-carry 4-bit adder; sum[k] is valid k cycles after sum[0].
REQ-004 The block SHALL have the port `cout`, an input of width 1: adder carry-out, valid in the same cycle as sum[3].
REQ-005 The block SHALL have the port `in_valid`, an input of width 1: marks the cycle in which sum[0] of a new addition is valid.
REQ-006 The block SHALL have the port `out_data`, an output of width 5: aligned result {cout, sum[3:0]} at the FIFO head.
REQ-007 The block SHALL have the port `out_valid`, an output of width 1: out_data holds a valid result.
REQ-008 The block SHALL have the port `out_ready`, an input of width 1: the consumer accepts out_data in a cycle where out_valid=1 and out_ready=1.
REQ-009 The block SHALL have the port `overflow`, an output of width 1: sticky flag, set when a result is dropped.
REQ-010 The block SHALL have the port `count`, an output of width 8: number of results accepted into the FIFO, mod 256.

Function
REQ-011 The block SHALL delay sum[0] by 3 register stages, sum[1] by 2, sum[2] by 1, and sum[3] and cout by 0, so all five bits of one addition align in one cycle.
REQ-012 The block SHALL delay in_valid by 3 register stages (v3) to qualify the aligned word.
REQ-013 The block SHALL, when in_valid=1 at cycle t, form the aligned word at cycle t+3 as {cout(t+3), sum[3](t+3), sum[2](t+2), sum[1](t+1), sum[0](t)}.
REQ-014 The block SHALL accept back-to-back in_valid every cycle, with independent operations in flight in the delay lines.
REQ-015 The block SHALL push the aligned word into a 2-entry FIFO at the rising edge that ends cycle t+3 when v3=1 and a slot is free; first visibility is out_data/out_valid at t+4, so latency is 4 cycles from in_valid to out_valid with an empty FIFO.
REQ-016 The block SHALL drive out_valid=1 whenever the FIFO is non-empty; out_data SHALL be the oldest entry.
REQ-017 A pop SHALL occur at a rising edge where out_valid=1 and out_ready=1.
REQ-018 out_data and out_valid SHALL be stable while out_valid=1 and out_ready=0.
REQ-019 The FIFO SHALL be in exactly one of three states: EMPTY (0 entries), ONE (1 entry) or FULL (2 entries).
REQ-020 EMPTY SHALL go to ONE on push; otherwise it SHALL remain EMPTY.
REQ-021 ONE SHALL go to FULL on push without pop.
REQ-022 ONE SHALL go to EMPTY on pop without push.
REQ-023 ONE SHALL remain ONE on simultaneous push and pop, and the new word SHALL become the head.
REQ-024 FULL SHALL go to ONE on pop without push.
REQ-025 FULL SHALL remain FULL on push with simultaneous pop; the pop frees the slot, so there is no drop.
REQ-026 A push with FULL and no pop SHALL drop the word; the FIFO contents SHALL remain unchanged, and overflow SHALL go to 1 at that edge.
REQ-027 overflow SHALL remain 1 until reset.
REQ-028 count SHALL increment by 1 on each accepted push and wrap from 255 to 0; dropped words SHALL NOT be counted.
REQ-029 The block SHALL keep the upstream adder's sum bit widths (4 bits plus carry); no arithmetic SHALL be performed on the data.

Reset
REQ-030 On rst=0 the block SHALL immediately clear all delay-line registers, v1..v3, FIFO storage and pointers, out_valid=0, out_data=5'b0, overflow=0 and count=8'h00, regardless of clk.
REQ-031 Operations in flight in the delay lines at reset assertion SHALL be discarded; no result SHALL emerge for them after reset release.
REQ-032 On reset release the first rising edge SHALL behave as normal operation; an in_valid sampled at that edge SHALL produce out_valid 4 cycles later.

Verification
REQ-033 The bench SHALL cover a single op: in_valid=1 at t with sum[0]=1, then sum[1]=0 at t+1, sum[2]=1 at t+2, sum[3]=1 and cout=1 at t+3, out_ready=1 -> out_valid=1 at t+4 only, out_data=5'b11101, count=1.
REQ-034 The bench SHALL cover back-to-back ops: in_valid=1 for 4 consecutive cycles with skewed values 0x03, 0x1F, 0x00, 0x0A and out_ready=1 -> out_data sequence 0x03, 0x1F, 0x00, 0x0A on t+4..t+7, count=4.
REQ-035 The bench SHALL cover backpressure: out_ready=0 with 3 ops issued on consecutive cycles -> FIFO FULL after 2 results, the 3rd result dropped, overflow=1, count=2; then out_ready=1 -> the first two results pop in order, and overflow stays 1.
REQ-036 The bench SHALL cover simultaneous push and pop: FIFO FULL, out_ready=1 in the same cycle a new v3 word arrives -> no drop, overflow stays 0, FIFO stays FULL, and order is preserved.
REQ-037 The bench SHALL cover reset mid-operation: in_valid=1 at t, rst=0 pulsed asynchronously between edges at t+2 -> outputs zero immediately, and no out_valid at t+4.
REQ-038 The bench SHALL cover count wrap: 256 accepted results -> count returns to 8'h00, and overflow stays 0.
